// File: rtl/acc_reg_n.sv
// acc_reg_n: parametrised datapath accumulator.
// Single-cycle load/clear/shift/rotate/inc/dec plus a multi-cycle shift-by-N
// (SHRN/SHLN) with a busy/done handshake. Opcodes 0-3 match the older
// 4-bit CLEAR/LOAD/HOLD/SHR accumulator.
// Optional feature: define SERIAL_FILL_EN so logical shifts take their fill
// bit from serial_in; otherwise the fill bit is 0.
module acc_reg_n #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   acc,
  output logic               carry_out,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic               msb
);

  typedef enum logic [3:0] {
    OP_CLEAR = 4'd0,
    OP_LOAD  = 4'd1,
    OP_HOLD  = 4'd2,
    OP_SHR   = 4'd3,
    OP_SHL   = 4'd4,
    OP_ASR   = 4'd5,
    OP_ROR   = 4'd6,
    OP_ROL   = 4'd7,
    OP_SHRN  = 4'd8,
    OP_SHLN  = 4'd9,
    OP_INC   = 4'd10,
    OP_DEC   = 4'd11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
  localparam logic [WIDTH:0]     EXT_ONE = (WIDTH + 1)'(1);

  state_e             state;
  logic [SHAMT_W-1:0] cnt;
  logic               shift_left;
  logic               fill;
  logic [WIDTH-1:0]   shr_val;
  logic [WIDTH-1:0]   shl_val;
  logic [WIDTH-1:0]   step_val;
  logic               step_carry;

`ifdef SERIAL_FILL_EN
  assign fill = serial_in;
`else
  logic unused_serial_in;
  assign unused_serial_in = serial_in;
  assign fill = 1'b0;
`endif

  // Shift candidates and the step used while a multi-cycle shift is running
  always_comb begin
    shr_val    = {fill, acc[WIDTH-1:1]};
    shl_val    = {acc[WIDTH-2:0], fill};
    step_val   = shift_left ? shl_val : shr_val;
    step_carry = shift_left ? acc[WIDTH-1] : acc[0];
  end

  // Opcode execution and the SHRN/SHLN sequencer, all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_left <= 1'b0;
      acc        <= '0;
      carry_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          case (op)
            OP_CLEAR: begin
              acc       <= '0;
              carry_out <= 1'b0;
            end
            OP_LOAD: begin
              acc       <= din;
              carry_out <= 1'b0;
            end
            OP_SHR: begin
              acc       <= shr_val;
              carry_out <= acc[0];
            end
            OP_SHL: begin
              acc       <= shl_val;
              carry_out <= acc[WIDTH-1];
            end
            OP_ASR: begin
              acc       <= {acc[WIDTH-1], acc[WIDTH-1:1]};
              carry_out <= acc[0];
            end
            OP_ROR: begin
              acc       <= {acc[0], acc[WIDTH-1:1]};
              carry_out <= acc[0];
            end
            OP_ROL: begin
              acc       <= {acc[WIDTH-2:0], acc[WIDTH-1]};
              carry_out <= acc[WIDTH-1];
            end
            OP_SHRN, OP_SHLN: begin
              shift_left <= (op == OP_SHLN);
              if (shamt == '0) begin
                done <= 1'b1;
              end else begin
                // The issue edge already performs the first step
                if (op == OP_SHLN) begin
                  acc       <= shl_val;
                  carry_out <= acc[WIDTH-1];
                end else begin
                  acc       <= shr_val;
                  carry_out <= acc[0];
                end
                cnt <= shamt - CNT_ONE;
                if (shamt == CNT_ONE) begin
                  done <= 1'b1;
                end else begin
                  state <= SHIFT;
                  busy  <= 1'b1;
                end
              end
            end
            OP_INC: {carry_out, acc} <= {1'b0, acc} + EXT_ONE;
            OP_DEC: {carry_out, acc} <= {1'b0, acc} - EXT_ONE;
            default: ;
          endcase
        end
        SHIFT: begin
          if (op == OP_CLEAR) begin
            acc       <= '0;
            carry_out <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            acc       <= step_val;
            carry_out <= step_carry;
            cnt       <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero = (acc == '0);
  assign msb  = acc[WIDTH-1];

endmodule

// File: tb/tb_acc_reg_n.sv
// Testbench for acc_reg_n: directed cases plus randomized opcodes, with an
// arithmetic reference model feeding a scoreboard queue and a monitor that
// compares every cycle's registered outputs.
module tb_acc_reg_n;

  localparam int W    = 4;
  localparam int SW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clock;
  logic          reset_n;
  logic [3:0]    op;
  logic [W-1:0]  din;
  logic [SW-1:0] shamt;
  logic          serial_in;
  logic [W-1:0]  acc;
  logic          carry_out;
  logic          busy;
  logic          done;
  logic          zero;
  logic          msb;

  acc_reg_n #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .op(op), .din(din), .shamt(shamt),
    .serial_in(serial_in), .acc(acc), .carry_out(carry_out), .busy(busy),
    .done(done), .zero(zero), .msb(msb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int a;
    int c;
    int b;
    int d;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: value, carry, remaining multi-cycle steps
  int m_acc, m_c, m_done, m_rem, m_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_done = 0; m_rem = 0; m_left = 0;
  endtask

  task automatic model_shift(input int left, input int f);
    if (left != 0) begin
      m_c   = (m_acc >> (W - 1)) & 1;
      m_acc = ((m_acc << 1) | f) & MASK;
    end else begin
      m_c   = m_acc & 1;
      m_acc = (m_acc >> 1) | (f << (W - 1));
    end
  endtask

  task automatic model_step(input int o, input int d, input int k, input int sin);
    int f;
    exp_t e;
`ifdef SERIAL_FILL_EN
    f = sin;
`else
    f = 0;
`endif
    m_done = 0;
    if (m_rem > 0) begin
      if (o == 0) begin
        m_acc = 0; m_c = 0; m_rem = 0;
      end else begin
        model_shift(m_left, f);
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else begin
      case (o)
        0: begin m_acc = 0; m_c = 0; end
        1: begin m_acc = d & MASK; m_c = 0; end
        3: model_shift(0, f);
        4: model_shift(1, f);
        5: begin m_c = m_acc & 1; m_acc = (m_acc >> 1) | (m_acc & (1 << (W - 1))); end
        6: begin m_c = m_acc & 1; m_acc = (m_acc >> 1) | (m_c << (W - 1)); end
        7: begin m_c = (m_acc >> (W - 1)) & 1; m_acc = ((m_acc << 1) | m_c) & MASK; end
        8, 9: begin
          m_left = (o == 9) ? 1 : 0;
          if (k == 0) m_done = 1;
          else begin
            model_shift(m_left, f);
            m_rem = k - 1;
            if (m_rem == 0) m_done = 1;
          end
        end
        10: begin m_c = (m_acc == MASK) ? 1 : 0; m_acc = (m_acc + 1) & MASK; end
        11: begin m_c = (m_acc == 0) ? 1 : 0; m_acc = (m_acc - 1) & MASK; end
        default: ;
      endcase
    end
    e.a = m_acc; e.c = m_c; e.b = (m_rem > 0) ? 1 : 0; e.d = m_done;
    q.push_back(e);
  endtask

  // Present one opcode for the next rising edge and record its expected result
  task automatic drive(input int o, input int d, input int k, input int sin);
    @(negedge clock);
    op = 4'(o); din = W'(d); shamt = SW'(k); serial_in = 1'(sin);
    model_step(o, d, k, sin);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic exp_state(input string name, input int a, input int c, input int b, input int d);
    check({name, ".acc"}, 32'(acc), 32'(a));
    check({name, ".carry"}, 32'(carry_out), 32'(c));
    check({name, ".busy"}, 32'(busy), 32'(b));
    check({name, ".done"}, 32'(done), 32'(d));
  endtask

  // Monitor: pop the expectation for each edge that had stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb.acc", 32'(acc), 32'(e.a));
        check("sb.carry", 32'(carry_out), 32'(e.c));
        check("sb.busy", 32'(busy), 32'(e.b));
        check("sb.done", 32'(done), 32'(e.d));
        check("sb.zero", 32'(zero), (e.a == 0) ? 32'd1 : 32'd0);
        check("sb.msb", 32'(msb), 32'((e.a >> (W - 1)) & 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; op = '0; din = '0; shamt = '0; serial_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    exp_state("reset", 0, 0, 0, 0);
    check("reset.zero", 32'(zero), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // Asynchronous reset mid-cycle after a LOAD
    drive(1, 4'hA, 0, 0);
    @(posedge clock);
    #3;
    check("load_a", 32'(acc), 32'hA);
    reset_n = 1'b0;
    #1;
    exp_state("async_rst", 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Single-cycle shifts
    drive(1, 4'b1011, 0, 0);
    drive(3, 0, 0, 0); settle(); exp_state("shr", 4'b0101, 1, 0, 0);
    drive(5, 0, 0, 0); settle(); exp_state("asr", 4'b0010, 1, 0, 0);
    drive(7, 0, 0, 0); settle(); exp_state("rol", 4'b0100, 0, 0, 0);
    drive(1, 4'b1000, 0, 0);
    drive(5, 0, 0, 0); settle(); exp_state("asr_neg", 4'b1100, 0, 0, 0);

    // Increment / decrement wrap
    drive(1, 4'hF, 0, 0);
    drive(10, 0, 0, 0); settle(); exp_state("inc_wrap", 0, 1, 0, 0);
    check("inc_wrap.zero", 32'(zero), 32'd1);
    drive(11, 0, 0, 0); settle(); exp_state("dec_wrap", 4'hF, 1, 0, 0);
    check("dec_wrap.msb", 32'(msb), 32'd1);

    // SHRN by 3 and by 0
    drive(1, 4'b1101, 0, 0);
    drive(8, 0, 3, 0); settle(); exp_state("shrn_1", 4'b0110, 1, 1, 0);
    drive(2, 0, 0, 0); settle(); exp_state("shrn_2", 4'b0011, 0, 1, 0);
    drive(2, 0, 0, 0); settle(); exp_state("shrn_3", 4'b0001, 1, 0, 1);
    drive(2, 0, 0, 0); settle(); exp_state("shrn_after", 4'b0001, 1, 0, 0);
    drive(8, 0, 0, 0); settle(); exp_state("shrn_0", 4'b0001, 1, 0, 1);

    // SHLN by 7 aborted by CLEAR on the third cycle
    drive(1, 4'hF, 0, 0);
    drive(9, 0, 7, 0);
    drive(2, 0, 0, 0);
    drive(0, 0, 0, 0); settle(); exp_state("shln_clear", 0, 0, 0, 0);
    drive(2, 0, 0, 0); settle(); exp_state("shln_clear_nodone", 0, 0, 0, 0);

    // LOAD while busy is ignored; let the shift complete
    drive(1, 4'hF, 0, 0);
    drive(9, 0, 7, 0);
    drive(1, 4'h5, 0, 0); settle(); exp_state("load_busy", 4'hC, 1, 1, 0);
    repeat (6) drive(2, 0, 0, 0);

    // Asynchronous reset during a multi-cycle shift
    drive(8, 0, 6, 0);
    drive(2, 0, 0, 0);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    exp_state("rst_mid_shift", 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_shift.nodone", 32'(done), 32'd0);

`ifdef SERIAL_FILL_EN
    drive(0, 0, 0, 0);
    drive(4, 0, 0, 1);
    drive(4, 0, 0, 0);
    drive(4, 0, 0, 1);
    drive(4, 0, 0, 1); settle(); exp_state("serial_fill", 4'b1011, 0, 0, 0);
`endif

    // Randomized opcode stream
    for (int i = 0; i < 3000; i++) begin
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, (1 << SW) - 1)), int'($urandom_range(0, 1)));
    end
    drive(2, 0, 0, 0);
    repeat (2) settle();
    check("sb.drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
